// File: rtl/value_limit_mux.sv
// value_limit_mux: time-multiplexed clamp / slew limiter feeding the DAC serialisers.
// Per-channel runtime limits, slew step, last output and clip statistics.
module value_limit_mux #(
  parameter int CHANNELS   = 8,
  parameter int CH_BITS    = 3,
  parameter int INPUT_BITS = 16,
  parameter int OUTPUT_MSB = 15,
  parameter int OUTPUT_LSB = 0,
  parameter int COUNT_BITS = 16,
  parameter logic signed [INPUT_BITS-1:0] DEFAULT_MIN = 16'sh8000,
  parameter logic signed [INPUT_BITS-1:0] DEFAULT_MAX = 16'sh7fff
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [CH_BITS-1:0]                   in_channel,
  input  logic signed [INPUT_BITS-1:0]         in_value,
  input  logic                                 cfg_we,
  input  logic [CH_BITS-1:0]                   cfg_channel,
  input  logic [1:0]                           cfg_sel,
  input  logic [INPUT_BITS-1:0]                cfg_data,
  input  logic                                 clear_stats,
  input  logic [CH_BITS-1:0]                   stat_channel,
  output logic                                 out_valid,
  output logic [CH_BITS-1:0]                   out_channel,
  output logic [OUTPUT_MSB-OUTPUT_LSB:0]       out_value,
  output logic                                 out_clip_low,
  output logic                                 out_clip_high,
  output logic                                 out_slewed,
  output logic [CHANNELS-1:0]                  sticky_clip,
  output logic [COUNT_BITS-1:0]                stat_count
);

  localparam int IW    = INPUT_BITS;
  localparam int XW    = INPUT_BITS + 1;
  localparam int OW    = OUTPUT_MSB - OUTPUT_LSB + 1;
  localparam int NSLOT = 2 ** CH_BITS;
  // One bit per encodable index, set only for implemented channels
  localparam logic [NSLOT-1:0] CH_OK = {NSLOT{1'b1}} >> (NSLOT - CHANNELS);

  typedef logic signed [IW-1:0] sval_t;
  typedef logic [IW-1:0]        uval_t;

  sval_t                 min_q  [CHANNELS];
  sval_t                 max_q  [CHANNELS];
  uval_t                 step_q [CHANNELS];
  sval_t                 last_q [CHANNELS];
  logic [COUNT_BITS-1:0] cnt_q  [CHANNELS];
  logic [CHANNELS-1:0]   sticky_q;
  logic [COUNT_BITS-1:0] stat_q;

  logic               s1_vld_q;
  logic [CH_BITS-1:0] s1_ch_q;
  sval_t              s1_val_q, s1_min_q, s1_max_q, s1_last_q;
  uval_t              s1_step_q;

  logic               s2_vld_q;
  logic [CH_BITS-1:0] s2_ch_q;
  logic [OW-1:0]      s2_val_q;
  logic               s2_lo_q, s2_hi_q, s2_sl_q;

  logic               out_vld_q;
  logic [CH_BITS-1:0] out_ch_q;
  logic [OW-1:0]      out_val_q;
  logic               out_lo_q, out_hi_q, out_sl_q;

  logic                 in_ok, cfg_ok;
  sval_t                last_d, t_d, f_d;
  logic                 lo_d, hi_d, sl_d;
  logic signed [XW-1:0] dif_d, r_d, lst_x, mn_x, mx_x;
  logic [XW-1:0]        mag_d;

  assign in_ok  = in_valid & CH_OK[in_channel];
  assign cfg_ok = cfg_we & CH_OK[cfg_channel];

  // Back-to-back same-channel samples take last from the result being computed now
  assign last_d = (s1_vld_q && s1_ch_q == in_channel) ? f_d
                                                      : last_q[in_channel];

  always_comb begin
    lo_d  = s1_val_q < s1_min_q;
    hi_d  = !lo_d && (s1_val_q > s1_max_q);
    t_d   = lo_d ? s1_min_q : (hi_d ? s1_max_q : s1_val_q);
    lst_x = {s1_last_q[IW-1], s1_last_q};
    mn_x  = {s1_min_q[IW-1], s1_min_q};
    mx_x  = {s1_max_q[IW-1], s1_max_q};
    dif_d = {t_d[IW-1], t_d} - lst_x;
    mag_d = dif_d[XW-1] ? -dif_d : dif_d;
    sl_d  = (s1_step_q != '0) && (mag_d > {1'b0, s1_step_q});
    r_d   = dif_d[XW-1] ? lst_x - {1'b0, s1_step_q}
                        : lst_x + {1'b0, s1_step_q};
    f_d   = t_d;
    // A slewed step may start from a last value outside freshly tightened limits
    if (sl_d) begin
      if (r_d < mn_x)      f_d = s1_min_q;
      else if (r_d > mx_x) f_d = s1_max_q;
      else                 f_d = r_d[IW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_val_q  <= '0;
      s1_min_q  <= DEFAULT_MIN;
      s1_max_q  <= DEFAULT_MAX;
      s1_step_q <= '0;
      s1_last_q <= '0;
    end else begin
      s1_vld_q <= in_ok;
      if (in_ok) begin
        s1_ch_q   <= in_channel;
        s1_val_q  <= in_value;
        s1_min_q  <= min_q[in_channel];
        s1_max_q  <= max_q[in_channel];
        s1_step_q <= step_q[in_channel];
        s1_last_q <= last_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        min_q[i]  <= DEFAULT_MIN;
        max_q[i]  <= DEFAULT_MAX;
        step_q[i] <= '0;
        last_q[i] <= '0;
      end
    end else begin
      if (cfg_ok) begin
        case (cfg_sel)
          2'd0:    min_q[cfg_channel]  <= cfg_data;
          2'd1:    max_q[cfg_channel]  <= cfg_data;
          2'd2:    step_q[cfg_channel] <= cfg_data;
          default: ;
        endcase
      end
      if (s1_vld_q) last_q[s1_ch_q] <= f_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_ch_q  <= '0;
      s2_val_q <= '0;
      s2_lo_q  <= 1'b0;
      s2_hi_q  <= 1'b0;
      s2_sl_q  <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_ch_q  <= s1_ch_q;
        s2_val_q <= f_d[OUTPUT_MSB:OUTPUT_LSB];
        s2_lo_q  <= lo_d;
        s2_hi_q  <= hi_d;
        s2_sl_q  <= sl_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_ch_q  <= '0;
      out_val_q <= '0;
      out_lo_q  <= 1'b0;
      out_hi_q  <= 1'b0;
      out_sl_q  <= 1'b0;
    end else begin
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_ch_q  <= s2_ch_q;
        out_val_q <= s2_val_q;
        out_lo_q  <= s2_lo_q;
        out_hi_q  <= s2_hi_q;
        out_sl_q  <= s2_sl_q;
      end
    end
  end

  // Clear first, so a clip landing on the same edge survives it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      stat_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      if (clear_stats) begin
        sticky_q <= '0;
        for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      end
      if (s2_vld_q && (s2_lo_q || s2_hi_q)) begin
        sticky_q[s2_ch_q] <= 1'b1;
        if (clear_stats)
          cnt_q[s2_ch_q] <= COUNT_BITS'(1);
        else if (cnt_q[s2_ch_q] != '1)
          cnt_q[s2_ch_q] <= cnt_q[s2_ch_q] + 1'b1;
      end
      stat_q <= CH_OK[stat_channel] ? cnt_q[stat_channel] : '0;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_channel   = out_ch_q;
  assign out_value     = out_val_q;
  assign out_clip_low  = out_lo_q;
  assign out_clip_high = out_hi_q;
  assign out_slewed    = out_sl_q;
  assign sticky_clip   = sticky_q;
  assign stat_count    = stat_q;

endmodule

// File: tb/tb_value_limit_mux.sv
// tb_value_limit_mux: directed vectors with hand-computed expectations.
// Six channels (so an out-of-range index exists) and 4-bit counters.
module tb_value_limit_mux;

  localparam int CH = 6;
  localparam int CB = 3;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [CB-1:0]     in_channel;
  logic signed [15:0] in_value;
  logic              cfg_we;
  logic [CB-1:0]     cfg_channel;
  logic [1:0]        cfg_sel;
  logic [15:0]       cfg_data;
  logic              clear_stats;
  logic [CB-1:0]     stat_channel;
  logic              out_valid;
  logic [CB-1:0]     out_channel;
  logic [15:0]       out_value;
  logic              out_clip_low, out_clip_high, out_slewed;
  logic [CH-1:0]     sticky_clip;
  logic [NB-1:0]     stat_count;

  int errors = 0;
  int checks = 0;

  logic [CB-1:0] b_ch  [16];
  logic [15:0]   b_val [16];
  logic [15:0]   b_exp [16];
  logic [2:0]    b_flg [16];

  value_limit_mux #(
    .CHANNELS(CH), .CH_BITS(CB), .COUNT_BITS(NB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_channel(in_channel), .in_value(in_value),
    .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .clear_stats(clear_stats),
    .stat_channel(stat_channel),
    .out_valid(out_valid), .out_channel(out_channel), .out_value(out_value),
    .out_clip_low(out_clip_low), .out_clip_high(out_clip_high),
    .out_slewed(out_slewed), .sticky_clip(sticky_clip),
    .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [CB-1:0] ch, input logic [1:0] sel,
                     input logic [15:0] d);
    cfg_we = 1'b1; cfg_channel = ch; cfg_sel = sel; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        in_valid = 1'b1; in_channel = b_ch[i]; in_value = b_val[i];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 2) begin
        chk("burst_valid", out_valid, 1);
        chk("burst_chan", out_channel, b_ch[i-2]);
        chk("burst_value", out_value, b_exp[i-2]);
        chk("burst_flags", {out_clip_low, out_clip_high, out_slewed},
            b_flg[i-2]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic vec(input int i, input logic [CB-1:0] ch,
                     input logic [15:0] v, input logic [15:0] e,
                     input logic [2:0] f);
    b_ch[i] = ch; b_val[i] = v; b_exp[i] = e; b_flg[i] = f;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_channel = '0; in_value = '0;
    cfg_we = 1'b0; cfg_channel = '0; cfg_sel = '0; cfg_data = '0;
    clear_stats = 1'b0; stat_channel = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_value", out_value, 0);
    chk("rst_chan", out_channel, 0);
    chk("rst_flags", {out_clip_low, out_clip_high, out_slewed}, 0);
    chk("rst_sticky", sticky_clip, 0);
    chk("rst_count", stat_count, 0);
    rst = 1'b0;
    tick();

    // pass-through with default limits
    vec(0, 3'd0, 16'h1234, 16'h1234, 3'b000);
    burst(1);
    tick();
    chk("single_strobe", out_valid, 0);
    chk("single_sticky", sticky_clip, 0);

    // clamp ch2 to [-100, 100]
    cfg(3'd2, 2'd0, 16'hFF9C);
    cfg(3'd2, 2'd1, 16'd100);
    stat_channel = 3'd2;
    vec(0, 3'd2, 16'd500,  16'd100,  3'b010);
    vec(1, 3'd2, 16'hFE0C, 16'hFF9C, 3'b100);
    vec(2, 3'd2, 16'd50,   16'd50,   3'b000);
    burst(3);
    chk("clamp_count", stat_count, 2);
    chk("clamp_sticky", sticky_clip, 6'b000100);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clear_sticky", sticky_clip, 0);
    tick();
    chk("clear_count", stat_count, 0);

    // slew ch1 by 10, back-to-back and around a ch3 sample
    cfg(3'd1, 2'd2, 16'd10);
    vec(0, 3'd1, 16'd100, 16'd10, 3'b001);
    vec(1, 3'd1, 16'd100, 16'd20, 3'b001);
    vec(2, 3'd3, 16'd77,  16'd77, 3'b000);
    vec(3, 3'd1, 16'd100, 16'd30, 3'b001);
    vec(4, 3'd1, 16'd100, 16'd40, 3'b001);
    burst(5);

    // counter saturation on ch0
    cfg(3'd0, 2'd1, 16'd0);
    stat_channel = 3'd0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_channel = 3'd0; in_value = 16'sd100;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("sat_count", stat_count, 15);
    chk("sat_sticky", sticky_clip, 6'b000001);
    in_valid = 1'b1; in_channel = 3'd0; in_value = 16'sd100;
    tick();
    in_valid = 1'b0;
    tick();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clrclip_valid", out_valid, 1);
    chk("clrclip_high", out_clip_high, 1);
    chk("clrclip_sticky", sticky_clip, 6'b000001);
    tick();
    chk("clrclip_count", stat_count, 1);

    // config write racing a same-channel sample on ch4
    in_valid = 1'b1; in_channel = 3'd4; in_value = 16'sd50;
    cfg_we = 1'b1; cfg_channel = 3'd4; cfg_sel = 2'd1; cfg_data = 16'd0;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_channel = 3'd4; cfg_sel = 2'd0; cfg_data = 16'd10;
    tick();
    cfg_we = 1'b0;
    chk("race_old_valid", out_valid, 1);
    chk("race_old_value", out_value, 50);
    chk("race_old_flags", {out_clip_low, out_clip_high, out_slewed}, 3'b000);
    in_valid = 1'b1; in_channel = 3'd4; in_value = 16'sd5;
    tick();
    in_valid = 1'b0;
    chk("race_new_value", out_value, 0);
    chk("race_new_flags", {out_clip_low, out_clip_high, out_slewed}, 3'b010);
    tick(); tick();
    chk("inv_lim_valid", out_valid, 1);
    chk("inv_lim_value", out_value, 10);
    chk("inv_lim_flags", {out_clip_low, out_clip_high, out_slewed}, 3'b100);

    // reset with samples in flight
    in_valid = 1'b1; in_channel = 3'd0; in_value = 16'sd7;
    tick();
    in_channel = 3'd2; in_value = 16'sd9;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_value", out_value, 0);
    chk("midrst_sticky", sticky_clip, 0);
    chk("midrst_count", stat_count, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", out_valid, 0);
    end

    in_valid = 1'b1; in_channel = 3'(CH); in_value = 16'sd5;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("drop_bad_chan", out_valid, 0);
    tick();
    chk("drop_bad_chan2", out_valid, 0);

    // limits, step and last all back to defaults
    vec(0, 3'd4, 16'd5,    16'd5,    3'b000);
    vec(1, 3'd2, 16'd500,  16'd500,  3'b000);
    vec(2, 3'd1, 16'd100,  16'd100,  3'b000);
    vec(3, 3'd0, 16'h8000, 16'h8000, 3'b000);
    burst(4);
    tick();
    chk("final_count", stat_count, 0);
    chk("final_sticky", sticky_clip, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/value_limit_mux.md
Name: value_limit_mux

Overview:
Time-multiplexed, multi-channel successor to the single-channel output limiter. One instance sits between the servo/PI accumulators and the DAC serialisers. For each sample it:
- clamps the signed input to per-channel, runtime-programmable min/max limits;
- optionally slew-limits the step relative to that channel's previous output;
- extracts the DAC bit slice;
- keeps sticky clip flags and saturating clip counters per channel.

Parameters:
CHANNELS, 8, number of channels (2..16)
CH_BITS, 3, width of channel index (CHANNELS <= 2**CH_BITS)
INPUT_BITS, 16, signed input/limit/step width
OUTPUT_MSB, 15, top bit of input slice sent to out_value
OUTPUT_LSB, 0, bottom bit of slice; OW = OUTPUT_MSB-OUTPUT_LSB+1
COUNT_BITS, 16, clip counter width
DEFAULT_MIN, 16'sh8000, reset value of every channel's min
DEFAULT_MAX, 16'sh7fff, reset value of every channel's max

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  sample strobe
in_channel  in  CH_BITS  sample channel
in_value  in  INPUT_BITS  signed sample
cfg_we  in  1  config write strobe
cfg_channel  in  CH_BITS  config target channel
cfg_sel  in  2  0=min, 1=max, 2=slew step, 3=reserved (ignored)
cfg_data  in  INPUT_BITS  config word (min/max signed; step unsigned)
clear_stats  in  1  clears all sticky flags and counters
stat_channel  in  CH_BITS  counter readback select
out_valid  out  1  result strobe
out_channel  out  CH_BITS  result channel
out_value  out  OW  clipped/slewed value[OUTPUT_MSB:OUTPUT_LSB]
out_clip_low  out  1  this sample hit min
out_clip_high  out  1  this sample hit max
out_slewed  out  1  this sample was slew-limited
sticky_clip  out  CHANNELS  per-channel sticky clip flag
stat_count  out  COUNT_BITS  clip count of stat_channel, registered (1-cycle latency)

Behaviour:
- Reset (async, rst=1): every register goes to its reset value.
  - Outputs: out_valid, out_value, out_channel, out_clip_low/high, out_slewed, sticky_clip and stat_count = 0.
  - Per-channel state: min=DEFAULT_MIN, max=DEFAULT_MAX, step=0, last=0, counters=0.
  - Reset mid-pipeline: in-flight samples are discarded; no out_valid after release until a new in_valid.
- Pipeline: 2-cycle latency, full throughput (one sample per clk, any channel order).
  - S1: register sample and read that channel's min, max, step and last.
  - S2: compute and register outputs; update last[ch].
  - A sample with in_valid at edge N gives out_valid=1 at edge N+2.
- Arithmetic, all signed INPUT_BITS, intermediates INPUT_BITS+1 (no overflow):
  - t = (v<min) ? min : (v>max) ? max : v. The low test has priority, so min>max yields min.
  - If step=0, r=t. Otherwise, if |t-last| > step, r = last ± step toward t; else r=t.
  - Final f = clamp(r) again, so output never exceeds current limits after limits are tightened.
  - out_value = f[OUTPUT_MSB:OUTPUT_LSB]; last[ch] <= f (full width).
- Flags:
  - out_clip_low/high reflect the first clamp only.
  - out_slewed=1 when step limiting altered r.
  - A clip event = out_clip_low|out_clip_high.
- Hazard: a same-channel sample in S1 while the previous one is in S2 must use the S2 result f as last (forwarding), not the stale register. Bench checks back-to-back same-channel slew.
- Config:
  - A write at edge N is used by samples entering S1 at edge N+1 or later.
  - A sample and a write to the same channel in the same cycle: the sample uses the old value.
  - cfg_sel=3 and cfg_channel >= CHANNELS are ignored.
- Invalid sample channel (in_channel >= CHANNELS): the sample is dropped, no out_valid, no state change.
- Stats:
  - On a clip event, sticky_clip[ch] <= 1 and count[ch] increments, saturating at all-ones (no wrap).
  - clear_stats zeroes all flags/counters. If a clip event occurs the same cycle, the event is applied after the clear (flag=1, count=1).
  - stat_count = count[stat_channel] registered.

Test Plan:
- Defaults, ch0, in 16'sh1234 -> out_valid 2 cycles later, out_value 16'h1234, no flags, sticky 0.
- ch2 min=-100, max=100; samples 500, -500, 50 -> outputs 100 (clip_high), -100 (clip_low), 50. sticky_clip[2]=1, stat_count(ch2)=2, then clear_stats -> 0.
- ch1 step=10, last 0; back-to-back ch1 samples 100,100,100 -> 10,20,30 with out_slewed=1 (verifies forwarding); interleaved ch3 unaffected.
- Saturation: COUNT_BITS=4, 20 clipping samples ch0 -> stat_count=15. Simultaneous clear+clip -> 1.
- Config same cycle as ch4 sample: new max=0, sample 50 -> output 50. Next sample 50 -> 0 with clip_high. min=10>max=0, sample 5 -> 10.
- Reset asserted with samples in S1/S2 -> no out_valid after release; all outputs 0, limits back to defaults; in_channel=CHANNELS dropped.
